// File: rtl/wb_bus_arbiter.sv
// Shares one Wishbone master between the instruction and data buses of the core.
// One transaction in flight, dbus-first priority with alternation, and a bus timeout.
module wb_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_ibus_req,
  input  logic [31:0] io_ibus_addr,
  output logic [31:0] io_ibus_inst,
  output logic        io_ibus_valid,
  input  logic        io_dbus_rd_en,
  input  logic        io_dbus_wr_en,
  input  logic [31:0] io_dbus_addr,
  input  logic [31:0] io_dbus_wdata,
  input  logic [3:0]  io_dbus_sel,
  output logic [31:0] io_dbus_rdata,
  output logic        io_dbus_valid,
  output logic        io_wb_cyc_o,
  output logic        io_wb_stb_o,
  output logic        io_wb_we_o,
  output logic [31:0] io_wb_adr_o,
  output logic [31:0] io_wb_dat_o,
  output logic [3:0]  io_wb_sel_o,
  input  logic [31:0] io_wb_dat_i,
  input  logic        io_wb_ack_i,
  input  logic        io_wb_err_i,
  output logic        io_bus_err,
  output logic [31:0] io_err_addr
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_dbus;
  logic             grant_dbus;
  logic             err_flag;

  logic dbus_pend;
  logic pick_dbus;
  logic timeout_hit;

  assign dbus_pend   = io_dbus_rd_en | io_dbus_wr_en;
  // Contested grants go to dbus unless dbus won the previous one.
  assign pick_dbus   = dbus_pend & (~io_ibus_req | ~last_dbus);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      last_dbus     <= 1'b0;
      grant_dbus    <= 1'b0;
      err_flag      <= 1'b0;
      io_ibus_inst  <= '0;
      io_ibus_valid <= 1'b0;
      io_dbus_rdata <= '0;
      io_dbus_valid <= 1'b0;
      io_wb_cyc_o   <= 1'b0;
      io_wb_stb_o   <= 1'b0;
      io_wb_we_o    <= 1'b0;
      io_wb_adr_o   <= '0;
      io_wb_dat_o   <= '0;
      io_wb_sel_o   <= '0;
      io_bus_err    <= 1'b0;
      io_err_addr   <= '0;
    end else begin
      io_ibus_valid <= 1'b0;
      io_dbus_valid <= 1'b0;
      io_bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (io_ibus_req || dbus_pend) begin
            grant_dbus  <= pick_dbus;
            last_dbus   <= pick_dbus;
            err_flag    <= 1'b0;
            io_wb_cyc_o <= 1'b1;
            io_wb_stb_o <= 1'b1;
            if (pick_dbus) begin
              io_wb_we_o  <= io_dbus_wr_en;
              io_wb_adr_o <= io_dbus_addr;
              io_wb_dat_o <= io_dbus_wdata;
              io_wb_sel_o <= io_dbus_sel;
            end else begin
              io_wb_we_o  <= 1'b0;
              io_wb_adr_o <= io_ibus_addr;
              io_wb_dat_o <= '0;
              io_wb_sel_o <= 4'hF;
            end
            state <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt + CNT_W'(1);
          // Error wins over a simultaneous ack; the requester sees zero data.
          if (io_wb_err_i || timeout_hit) begin
            io_wb_cyc_o <= 1'b0;
            io_wb_stb_o <= 1'b0;
            if (grant_dbus) io_dbus_rdata <= '0;
            else            io_ibus_inst  <= '0;
            io_err_addr <= io_wb_adr_o;
            err_flag    <= 1'b1;
            state       <= RESP;
          end else if (io_wb_ack_i) begin
            io_wb_cyc_o <= 1'b0;
            io_wb_stb_o <= 1'b0;
            if (grant_dbus) io_dbus_rdata <= io_wb_we_o ? 32'h0 : io_wb_dat_i;
            else            io_ibus_inst  <= io_wb_dat_i;
            err_flag    <= 1'b0;
            state       <= RESP;
          end
        end
        RESP: begin
          cnt <= '0;
          if (grant_dbus) io_dbus_valid <= 1'b1;
          else            io_ibus_valid <= 1'b1;
          io_bus_err <= err_flag;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Scoreboard bench for wb_bus_arbiter: a scripted Wishbone slave answers each grant,
// expected completions are queued when a request is driven and matched on each valid strobe.
module tb_wb_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_ibus_req = 1'b0;
  logic [31:0] io_ibus_addr = '0;
  logic [31:0] io_ibus_inst;
  logic        io_ibus_valid;
  logic        io_dbus_rd_en = 1'b0;
  logic        io_dbus_wr_en = 1'b0;
  logic [31:0] io_dbus_addr = '0;
  logic [31:0] io_dbus_wdata = '0;
  logic [3:0]  io_dbus_sel = '0;
  logic [31:0] io_dbus_rdata;
  logic        io_dbus_valid;
  logic        io_wb_cyc_o;
  logic        io_wb_stb_o;
  logic        io_wb_we_o;
  logic [31:0] io_wb_adr_o;
  logic [31:0] io_wb_dat_o;
  logic [3:0]  io_wb_sel_o;
  logic [31:0] io_wb_dat_i = '0;
  logic        io_wb_ack_i = 1'b0;
  logic        io_wb_err_i = 1'b0;
  logic        io_bus_err;
  logic [31:0] io_err_addr;

  wb_bus_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .io_ibus_req(io_ibus_req), .io_ibus_addr(io_ibus_addr),
    .io_ibus_inst(io_ibus_inst), .io_ibus_valid(io_ibus_valid),
    .io_dbus_rd_en(io_dbus_rd_en), .io_dbus_wr_en(io_dbus_wr_en),
    .io_dbus_addr(io_dbus_addr), .io_dbus_wdata(io_dbus_wdata),
    .io_dbus_sel(io_dbus_sel), .io_dbus_rdata(io_dbus_rdata),
    .io_dbus_valid(io_dbus_valid),
    .io_wb_cyc_o(io_wb_cyc_o), .io_wb_stb_o(io_wb_stb_o), .io_wb_we_o(io_wb_we_o),
    .io_wb_adr_o(io_wb_adr_o), .io_wb_dat_o(io_wb_dat_o), .io_wb_sel_o(io_wb_sel_o),
    .io_wb_dat_i(io_wb_dat_i), .io_wb_ack_i(io_wb_ack_i), .io_wb_err_i(io_wb_err_i),
    .io_bus_err(io_bus_err), .io_err_addr(io_err_addr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_dbus;
    logic [31:0] data;
    logic        err;
    logic [31:0] err_addr;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cycle_count = 0;
  int   grant_cycle = 0;

  always @(posedge clock) cycle_count <= cycle_count + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", tag, actual, expected, $time);
    end
  endtask

  // Drives one requester; queues the expected completion when push is set.
  task automatic applyStimulus(input logic is_dbus, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] sel, input logic push,
                               input logic [31:0] exp_data, input logic exp_err);
    exp_t e;
    if (is_dbus) begin
      io_dbus_rd_en = ~wr;
      io_dbus_wr_en = wr;
      io_dbus_addr  = addr;
      io_dbus_wdata = wdata;
      io_dbus_sel   = sel;
    end else begin
      io_ibus_req  = 1'b1;
      io_ibus_addr = addr;
    end
    if (push) begin
      e.is_dbus  = is_dbus;
      e.data     = exp_data;
      e.err      = exp_err;
      e.err_addr = addr;
      sbq.push_back(e);
    end
  endtask

  // Scripted slave: waits for a cycle, holds for some wait states, then acks and/or errs.
  task automatic serveBus(input int waits, input logic [31:0] rdata, input logic do_ack,
                          input logic do_err, output logic [31:0] adr, output logic we,
                          output logic [3:0] sel, output logic [31:0] dat, output int busy);
    int guard;
    guard = 0;
    busy  = 0;
    adr = '0; we = 1'b0; sel = '0; dat = '0;
    while (!io_wb_cyc_o && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (!io_wb_cyc_o) begin
      checkOutput("cyc_wait", 32'(io_wb_cyc_o), 32'h1);
      return;
    end
    grant_cycle = cycle_count;
    adr = io_wb_adr_o; we = io_wb_we_o; sel = io_wb_sel_o; dat = io_wb_dat_o;
    busy = 1;
    checkOutput("stb", 32'(io_wb_stb_o), 32'h1);
    if (do_ack || do_err) begin
      for (int i = 0; i < waits; i++) begin
        @(negedge clock);
        busy++;
        checkOutput("hold_cyc", 32'(io_wb_cyc_o), 32'h1);
        checkOutput("hold_adr", io_wb_adr_o, adr);
        checkOutput("hold_dat", io_wb_dat_o, dat);
      end
      io_wb_ack_i = do_ack;
      io_wb_err_i = do_err;
      io_wb_dat_i = rdata;
      @(negedge clock);
      io_wb_ack_i = 1'b0;
      io_wb_err_i = 1'b0;
      checkOutput("cyc_drop", 32'(io_wb_cyc_o), 32'h0);
    end else begin
      @(negedge clock);
      while (io_wb_cyc_o && guard < 50) begin
        busy++;
        @(negedge clock);
        guard++;
      end
    end
  endtask

  task automatic waitValid(input logic want_dbus);
    int g;
    g = 0;
    while (!(want_dbus ? io_dbus_valid : io_ibus_valid) && g < 20) begin
      @(negedge clock);
      g++;
    end
    checkOutput(want_dbus ? "dbus_valid_seen" : "ibus_valid_seen",
                32'(want_dbus ? io_dbus_valid : io_ibus_valid), 32'h1);
  endtask

  // Monitor: every completion strobe must match the oldest queued expectation.
  always @(negedge clock) begin
    if (reset && (io_ibus_valid || io_dbus_valid)) begin
      if (sbq.size() == 0) begin
        checkOutput("sb_unexpected", 32'h1, 32'h0);
      end else begin
        mon_e = sbq.pop_front();
        checkOutput("sb_who", 32'(io_dbus_valid), 32'(mon_e.is_dbus));
        checkOutput("sb_both", 32'(io_ibus_valid & io_dbus_valid), 32'h0);
        checkOutput("sb_data", mon_e.is_dbus ? io_dbus_rdata : io_ibus_inst, mon_e.data);
        checkOutput("sb_err", 32'(io_bus_err), 32'(mon_e.err));
        if (mon_e.err) checkOutput("sb_err_addr", io_err_addr, mon_e.err_addr);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] adr, dat;
    logic        we;
    logic [3:0]  sel;
    int          busy;
    logic        want_dbus;

    repeat (2) @(negedge clock);
    checkOutput("rst_cyc", 32'(io_wb_cyc_o), 32'h0);
    checkOutput("rst_ivalid", 32'(io_ibus_valid), 32'h0);
    checkOutput("rst_dvalid", 32'(io_dbus_valid), 32'h0);
    checkOutput("rst_adr", io_wb_adr_o, 32'h0);
    checkOutput("rst_err", 32'(io_bus_err), 32'h0);
    reset = 1'b1;
    @(negedge clock);

    $display("[TB] ibus fetch, ack in first busy cycle");
    applyStimulus(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b1, 32'h0000_0013, 1'b0);
    serveBus(0, 32'h0000_0013, 1'b1, 1'b0, adr, we, sel, dat, busy);
    checkOutput("t1_adr", adr, 32'h0000_0100);
    checkOutput("t1_we", 32'(we), 32'h0);
    checkOutput("t1_sel", 32'(sel), 32'hF);
    checkOutput("t1_dat", dat, 32'h0);
    waitValid(1'b0);
    checkOutput("t1_latency", 32'(cycle_count - grant_cycle), 32'd2);
    io_ibus_req = 1'b0;
    @(negedge clock);
    checkOutput("t1_pulse", 32'(io_ibus_valid), 32'h0);

    $display("[TB] dbus write, three wait states");
    applyStimulus(1'b1, 1'b1, 32'h4000_0004, 32'hA5A5_5A5A, 4'h3, 1'b1, 32'h0, 1'b0);
    serveBus(3, 32'hDEAD_BEEF, 1'b1, 1'b0, adr, we, sel, dat, busy);
    checkOutput("t2_adr", adr, 32'h4000_0004);
    checkOutput("t2_we", 32'(we), 32'h1);
    checkOutput("t2_sel", 32'(sel), 32'h3);
    checkOutput("t2_dat", dat, 32'hA5A5_5A5A);
    checkOutput("t2_busy", 32'(busy), 32'd4);
    waitValid(1'b1);
    io_dbus_wr_en = 1'b0;
    @(negedge clock);

    $display("[TB] dbus read, slave never answers");
    applyStimulus(1'b1, 1'b0, 32'h2000_0000, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1);
    serveBus(0, 32'h0, 1'b0, 1'b0, adr, we, sel, dat, busy);
    checkOutput("t3_busy", 32'(busy), 32'd8);
    waitValid(1'b1);
    io_dbus_rd_en = 1'b0;
    @(negedge clock);

    $display("[TB] ibus fetch, err and ack together");
    applyStimulus(1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1);
    serveBus(1, 32'h1234_5678, 1'b1, 1'b1, adr, we, sel, dat, busy);
    waitValid(1'b0);
    io_ibus_req = 1'b0;
    @(negedge clock);

    $display("[TB] asynchronous reset mid-transaction");
    applyStimulus(1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clock);
    checkOutput("t5_cyc_up", 32'(io_wb_cyc_o), 32'h1);
    #2 reset = 1'b0;
    #1;
    checkOutput("t5_cyc_async", 32'(io_wb_cyc_o), 32'h0);
    checkOutput("t5_stb_async", 32'(io_wb_stb_o), 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h3000_0000, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clock);
    checkOutput("t5_no_ivalid", 32'(io_ibus_valid), 32'h0);
    reset = 1'b1;

    $display("[TB] both requesters continuously pending");
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.is_dbus  = (i % 2 == 0);
      e.data     = 32'hC0DE_0000 + 32'(i);
      e.err      = 1'b0;
      e.err_addr = '0;
      sbq.push_back(e);
    end
    for (int i = 0; i < 4; i++) begin
      want_dbus = (i % 2 == 0);
      serveBus(i, 32'hC0DE_0000 + 32'(i), 1'b1, 1'b0, adr, we, sel, dat, busy);
      checkOutput("t6_order_adr", adr, want_dbus ? 32'h3000_0000 : 32'h0000_0300);
      waitValid(want_dbus);
    end
    io_ibus_req   = 1'b0;
    io_dbus_rd_en = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("sb_drained", 32'(sbq.size()), 32'h0);
    checkOutput("idle_cyc", 32'(io_wb_cyc_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Shares one Wishbone master port between the core instruction bus (ibus) and data bus (dbus).
- Sits between the core and the Wishbone interconnect.
- Fixed-priority arbitration with anti-starvation alternation, one outstanding transaction, bus-timeout detection.
- Returns read data and a one-cycle valid strobe to the granted requester.

Parameters:
- TIMEOUT_CYCLES, 255: cycles to wait for ack/err before forcing an error completion; 0 disables the timeout.
- CNT_W, 8: timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous active-low reset; asserted when 0.
- io_ibus_req  in  1  fetch request; level, held until io_ibus_valid.
- io_ibus_addr  in  32  fetch address.
- io_ibus_inst  out  32  fetched instruction.
- io_ibus_valid  out  1  one-cycle completion strobe for ibus.
- io_dbus_rd_en  in  1  load request; level, held until io_dbus_valid.
- io_dbus_wr_en  in  1  store request; level, held until io_dbus_valid.
- io_dbus_addr  in  32  data address.
- io_dbus_wdata  in  32  store data.
- io_dbus_sel  in  4  byte-lane select.
- io_dbus_rdata  out  32  load data.
- io_dbus_valid  out  1  one-cycle completion strobe for dbus.
- io_wb_cyc_o  out  1  Wishbone cycle.
- io_wb_stb_o  out  1  Wishbone strobe.
- io_wb_we_o  out  1  Wishbone write enable.
- io_wb_adr_o  out  32  Wishbone address.
- io_wb_dat_o  out  32  Wishbone write data.
- io_wb_sel_o  out  4  Wishbone byte select.
- io_wb_dat_i  in  32  Wishbone read data.
- io_wb_ack_i  in  1  Wishbone acknowledge.
- io_wb_err_i  in  1  Wishbone error.
- io_bus_err  out  1  one-cycle pulse: transaction ended by err_i or timeout.
- io_err_addr  out  32  address of the most recent failed transaction.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; timeout counter 0.
  - last_grant = IBUS, so the first contested grant goes to dbus.
  - Reset is asynchronous: a mid-transaction reset drops cyc/stb immediately. No completion strobe is issued for the aborted transaction.
- All outputs are registered. The state machine has three states: IDLE, BUSY, RESP.
- IDLE:
  - dbus pending = rd_en | wr_en.
  - If only one requester is pending, grant it.
  - If both are pending, grant dbus unless last_grant == DBUS, in which case grant ibus (alternation).
  - On grant: latch adr/dat/sel/we into the wb_* registers and set cyc = stb = 1.
  - ibus grant drives we = 0, sel = 4'hF, dat_o = 0.
  - dbus with wr_en = 1 drives a write (wr_en has precedence if rd_en is also high).
  - Update last_grant and go to BUSY.
- BUSY:
  - Master outputs are held stable. The counter increments every cycle.
  - ack_i sampled high: capture dat_i into the granted requester's data output (ibus_inst or dbus_rdata; for writes dbus_rdata = 0). Clear cyc/stb and go to RESP.
  - err_i sampled high (err has precedence over a simultaneous ack), or counter == TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES != 0:
    - clear cyc/stb;
    - set the requester's data output to 0;
    - latch io_err_addr = wb_adr_o;
    - go to RESP with an error flag.
- RESP:
  - Exactly one cycle. The granted requester's valid = 1, and io_bus_err = 1 if the error flag is set.
  - No new grant is made this cycle. Counter clears; next state IDLE.
  - Requesters must sample data on valid and drop or replace the request the following cycle. A request still high in IDLE is treated as a new transaction.
- Latency: with ack returned in the first BUSY cycle, request seen at edge E0 gives cyc at E0+, ack sampled at E1, and valid high between E2 and E3. That is 2 cycles minimum, plus one cycle of IDLE turnaround before the next grant.
- Data outputs hold their last value between strobes. io_err_addr holds until the next error.
- Inputs that change during BUSY have no effect on the master port.

Test Plan:
- ibus_req=1, addr=0x0000_0100, slave acks on 1st BUSY cycle with dat_i=0x0000_0013 -> wb_adr_o=0x100, we=0, sel=0xF; io_ibus_valid pulses 1 cycle with inst=0x13, 2 cycles after request.
- dbus wr_en=1, addr=0x4000_0004, wdata=0xA5A5_5A5A, sel=0x3, ack after 3 wait cycles -> we=1, dat_o=0xA5A5_5A5A, sel_o=0x3 stable for 4 cycles; io_dbus_valid 1 cycle, rdata=0.
- ibus and dbus requesting continuously from reset -> grant order dbus, ibus, dbus, ibus; never two consecutive grants to one requester while the other waits.
- TIMEOUT_CYCLES=8, dbus rd_en=1 to 0x2000_0000, no ack -> cyc drops after 8 BUSY cycles; dbus_valid=1, rdata=0, io_bus_err=1, io_err_addr=0x2000_0000.
- err_i and ack_i asserted together for an ibus fetch -> error completion: inst=0, io_bus_err=1.
- reset driven low during BUSY -> cyc/stb drop without waiting for a clock edge, no valid strobe; after release, a pending dbus request wins over ibus.
